mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage: EX/MEM register, data-memory access, MEM/WB register.
- It is the producer end of the EX-stage forwarding interface. It drives EX_MEM_data, EX_MEM_RegWrite, EX_MEM_RegisterRd, MEM_WB_data, MEM_WB_RegWrite and MEM_WB_RegisterRd back to the forwarding unit and muxes.
- Data memory is reached over a req/ack port of variable latency.
- mem_stall freezes IF/ID/EX while an access is outstanding. A bus timeout aborts hung accesses.

Parameters:
- DATA_W, 32, datapath and address width.
- TIMEOUT, 15, maximum wait cycles for dmem_ack before an access is aborted (range 1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- EX_MemtoReg_out, EX_RegWrite_out, EX_MemRead_out, EX_MemWrite_out  input  1 each  control from EX (already flush-gated).
- alu_result  input  DATA_W  EX ALU result; used as the memory address.
- write_data  input  DATA_W  store data from EX.
- write_reg  input  5  destination register from EX.
- dmem_req  output  1  memory request.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  DATA_W  word address.
- dmem_wdata  output  DATA_W  store data.
- dmem_ack  input  1  access complete.
- dmem_rdata  input  DATA_W  load data; valid when dmem_ack=1.
- mem_stall  output  1  freeze upstream stages.
- mem_err  output  1  sticky timeout flag.
- EX_MEM_data  output  DATA_W  EX/MEM ALU result.
- EX_MEM_RegWrite  output  1  EX/MEM write enable.
- EX_MEM_RegisterRd  output  5  EX/MEM destination register.
- MEM_WB_data  output  DATA_W  write-back value.
- MEM_WB_RegWrite  output  1  MEM/WB write enable.
- MEM_WB_RegisterRd  output  5  MEM/WB destination register.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - EX/MEM and MEM/WB registers cleared (all fields 0).
  - FSM to IDLE, wait counter 0, mem_err 0.
  - dmem_req and mem_stall are 0 from the same instant.
- memop = exmem_MemRead | exmem_MemWrite, where the exmem_ fields are the EX/MEM register contents.
- dmem_req = memop and not aborted. dmem_we = exmem_MemWrite. dmem_addr = EX_MEM_data. dmem_wdata = exmem write_data.
- All dmem outputs stay stable while dmem_req=1.
- mem_stall = memop & ~dmem_ack & ~timeout_hit. It is combinational, so a zero-wait ack causes no stall cycle.
- FSM states:
  - IDLE: if memop & ~dmem_ack, go to WAIT with counter=1.
  - WAIT: on dmem_ack, go to IDLE. Else if counter==TIMEOUT, timeout_hit=1 for this cycle, set mem_err, go to IDLE. Else counter+1.
  - The counter never wraps.
- Access completes on the cycle with dmem_ack=1 or timeout_hit=1 (the complete cycle).
- Not stalled (mem_stall=0), at the rising edge:
  - EX/MEM loads the EX inputs.
  - MEM/WB loads the stage result:
    - MEM_WB_data = dmem_rdata if exmem_MemtoReg and the access was acked.
    - MEM_WB_data = 0 for a timed-out load.
    - MEM_WB_data = EX_MEM_data otherwise.
    - MEM_WB_RegWrite = exmem_RegWrite, forced 0 for a timed-out load.
    - MEM_WB_RegisterRd = exmem RegisterRd.
- Stalled: EX/MEM and MEM/WB both hold. MEM/WB is not bubbled, so forwarding from MEM/WB stays valid for the frozen EX instruction. Repeated regfile write-back of the same value is harmless.
- dmem_ack while memop=0 is ignored. dmem_rdata is sampled only on a complete cycle.
- Back-to-back memory ops: the next op's request asserts the cycle after the previous completes. The FSM is in IDLE then, so the counter restarts.
- EX_MEM_RegWrite, EX_MEM_RegisterRd and EX_MEM_data always reflect the current EX/MEM contents, including while stalled.
- mem_err clears only on rst.

Test Plan:
1. rst pulse asserted mid-cycle -> all outputs 0 immediately.
   - Release, ALU op (RegWrite=1, rd=5, alu_result=0x1234) -> next edge EX_MEM_RegisterRd=5, EX_MEM_data=0x1234.
   - One edge later MEM_WB_data=0x1234, MEM_WB_RegWrite=1, rd=5.
2. Load from address 0x40, ack 3 cycles after request with rdata=0xCAFEF00D -> dmem_req high 4 cycles, mem_stall high 3 cycles.
   - Next edge MEM_WB_data=0xCAFEF00D. MEM/WB holds the prior value throughout the stall.
3. Store to 0x80 data 0xA5A5A5A5, ack in the same cycle -> no stall, one-cycle req with dmem_we=1.
   - MEM_WB_RegWrite=0 for the store.
4. Load with no ack, TIMEOUT=15 -> dmem_req high 16 cycles, then drops.
   - mem_err=1, MEM_WB_RegWrite=0, MEM_WB_data=0. The pipeline resumes.
5. Two back-to-back loads, each acked after 1 cycle -> the counter restarts per access.
   - Correct rdata reaches MEM/WB in order.
6. rst asserted during WAIT -> dmem_req drops asynchronously and the FSM goes to IDLE.
   - A subsequent load completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// The master drives a request that is held stable until the memory acknowledges it.
interface mem_stage_if #(
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, variable-latency data-memory access with
// bus timeout, and MEM/WB register; also feeds both registers back for forwarding.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MemtoReg_out,
  input  logic              EX_RegWrite_out,
  input  logic              EX_MemRead_out,
  input  logic              EX_MemWrite_out,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        write_reg,
  mem_stage_if.master       dmem,
  output logic              mem_stall,
  output logic              mem_err,
  output logic [DATA_W-1:0] EX_MEM_data,
  output logic              EX_MEM_RegWrite,
  output logic [4:0]        EX_MEM_RegisterRd,
  output logic [DATA_W-1:0] MEM_WB_data,
  output logic              MEM_WB_RegWrite,
  output logic [4:0]        MEM_WB_RegisterRd
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              m2r_q, m2r_d;
  logic              rw_q, rw_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;

  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_rw_q, wb_rw_d;
  logic [4:0]        wb_rd_q, wb_rd_d;

  logic memop;
  logic acked;
  logic timeout_hit;
  logic stall;
  logic load_abort;

  always_comb begin
    memop       = rd_en_q | wr_en_q;
    acked       = memop & dmem.dmem_ack;
    timeout_hit = memop & (state_q == S_WAIT) & ~dmem.dmem_ack & (cnt_q == TIMEOUT_C);
    stall       = memop & ~dmem.dmem_ack & ~timeout_hit;
    load_abort  = timeout_hit & rd_en_q;
  end

  // Wait counter tracks cycles since the request went out; cleared whenever the access ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | timeout_hit;
    case (state_q)
      S_IDLE: begin
        if (memop && !acked) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        if (acked || timeout_hit || !memop) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Both pipeline registers hold while stalled; MEM/WB is deliberately not bubbled.
  always_comb begin
    m2r_d     = m2r_q;
    rw_d      = rw_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    data_d    = data_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wb_rw_d   = wb_rw_q;
    wb_rd_d   = wb_rd_q;
    if (!stall) begin
      m2r_d   = EX_MemtoReg_out;
      rw_d    = EX_RegWrite_out;
      rd_en_d = EX_MemRead_out;
      wr_en_d = EX_MemWrite_out;
      data_d  = alu_result;
      wdata_d = write_data;
      rd_d    = write_reg;
      if (acked && m2r_q) begin
        wb_data_d = dmem.dmem_rdata;
      end else if (load_abort) begin
        wb_data_d = '0;
      end else begin
        wb_data_d = data_q;
      end
      wb_rw_d = rw_q & ~load_abort;
      wb_rd_d = rd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      m2r_q     <= 1'b0;
      rw_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wb_rw_q   <= 1'b0;
      wb_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      m2r_q     <= m2r_d;
      rw_q      <= rw_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wb_rw_q   <= wb_rw_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  // The request ends with the access: the completing edge replaces EX/MEM.
  assign dmem.dmem_req   = memop;
  assign dmem.dmem_we    = wr_en_q;
  assign dmem.dmem_addr  = data_q;
  assign dmem.dmem_wdata = wdata_q;

  assign mem_stall         = stall;
  assign mem_err           = err_q;
  assign EX_MEM_data       = data_q;
  assign EX_MEM_RegWrite   = rw_q;
  assign EX_MEM_RegisterRd = rd_q;
  assign MEM_WB_data       = wb_data_q;
  assign MEM_WB_RegWrite   = wb_rw_q;
  assign MEM_WB_RegisterRd = wb_rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random instruction streams, checked
// cycle by cycle against a transaction-level model of the MEM stage.
module tb_mem_stage;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  typedef struct {
    bit          is_ld;
    bit          is_st;
    bit          m2r;
    bit          rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    int          lat;     // cycles from first request to ack; > TIMEOUT means never acked
    logic [31:0] rdata;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        EX_MemtoReg_out = 1'b0;
  logic        EX_RegWrite_out = 1'b0;
  logic        EX_MemRead_out  = 1'b0;
  logic        EX_MemWrite_out = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  write_reg  = '0;
  logic        mem_stall;
  logic        mem_err;
  logic [31:0] EX_MEM_data;
  logic        EX_MEM_RegWrite;
  logic [4:0]  EX_MEM_RegisterRd;
  logic [31:0] MEM_WB_data;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_RegisterRd;

  mem_stage_if #(.DATA_W(DATA_W)) dm ();

  mem_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .EX_MemtoReg_out   (EX_MemtoReg_out),
    .EX_RegWrite_out   (EX_RegWrite_out),
    .EX_MemRead_out    (EX_MemRead_out),
    .EX_MemWrite_out   (EX_MemWrite_out),
    .alu_result        (alu_result),
    .write_data        (write_data),
    .write_reg         (write_reg),
    .dmem              (dm.master),
    .mem_stall         (mem_stall),
    .mem_err           (mem_err),
    .EX_MEM_data       (EX_MEM_data),
    .EX_MEM_RegWrite   (EX_MEM_RegWrite),
    .EX_MEM_RegisterRd (EX_MEM_RegisterRd),
    .MEM_WB_data       (MEM_WB_data),
    .MEM_WB_RegWrite   (MEM_WB_RegWrite),
    .MEM_WB_RegisterRd (MEM_WB_RegisterRd)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  int   n_ops   = 0;

  op_t  pending[$];
  op_t  mem_op;
  int   k;
  logic [31:0] m_wb_data;
  bit          m_wb_rw;
  logic [4:0]  m_wb_rd;
  bit          m_err;

  function automatic op_t nop();
    op_t o;
    o.is_ld = 0; o.is_st = 0; o.m2r = 0; o.rw = 0; o.rd = '0;
    o.alu = '0; o.wd = '0; o.lat = 0; o.rdata = '0;
    return o;
  endfunction

  // kind: 0 = ALU, 1 = load, 2 = store
  function automatic op_t mk(int kind, bit rw, logic [4:0] rd, logic [31:0] alu,
                             logic [31:0] wd, int lat, logic [31:0] rdata);
    op_t o;
    o = nop();
    o.is_ld = (kind == 1);
    o.is_st = (kind == 2);
    o.m2r   = (kind == 1);
    o.rw    = rw;
    o.rd    = rd;
    o.alu   = alu;
    o.wd    = wd;
    o.lat   = lat;
    o.rdata = rdata;
    return o;
  endfunction

  function automatic op_t rand_op();
    int kind;
    int lat;
    kind = $urandom_range(0, 2);
    if ($urandom_range(0, 11) == 0) lat = TIMEOUT + 5;
    else if ($urandom_range(0, 15) == 0) lat = TIMEOUT;
    else lat = $urandom_range(0, 4);
    return mk(kind, (kind == 2) ? 1'b0 : ((kind == 1) ? 1'b1 : 1'($urandom_range(0, 1))),
              5'($urandom), $urandom, $urandom, lat, $urandom);
  endfunction

  function automatic bit is_mem(op_t o);
    return o.is_ld | o.is_st;
  endfunction

  // Cycles an op spends in MEM: ALU ops one; memory ops wait for ack or give up after TIMEOUT.
  function automatic int occupancy(op_t o);
    if (!is_mem(o)) return 1;
    return ((o.lat > TIMEOUT) ? TIMEOUT : o.lat) + 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic drive_ex(op_t o);
    EX_MemtoReg_out = o.m2r;
    EX_RegWrite_out = o.rw;
    EX_MemRead_out  = o.is_ld;
    EX_MemWrite_out = o.is_st;
    alu_result      = o.alu;
    write_data      = o.wd;
    write_reg       = o.rd;
  endtask

  task automatic retire(op_t o);
    string kind;
    kind = o.is_ld ? "load " : (o.is_st ? "store" : "alu  ");
    if (is_mem(o) && o.lat > TIMEOUT) begin
      m_err = 1;
      if (o.is_ld) begin
        m_wb_data = '0;
        m_wb_rw   = 0;
      end else begin
        m_wb_data = o.alu;
        m_wb_rw   = o.rw;
      end
    end else begin
      m_wb_data = (is_mem(o) && o.m2r) ? o.rdata : o.alu;
      m_wb_rw   = o.rw;
    end
    m_wb_rd = o.rd;
    if (is_mem(o) || o.rw) begin
      n_ops++;
      $display("txn %0d: %s addr=%h lat=%0d -> wb rd=%0d we=%0b data=%h",
               n_ops, kind, o.alu, o.lat, m_wb_rd, m_wb_rw, m_wb_data);
    end
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step();
    op_t ex;
    bit  mem;
    bit  ack_now;
    bit  exp_stall;
    if (pending.size() > 0) ex = pending[0];
    else ex = nop();
    drive_ex(ex);
    mem       = is_mem(mem_op);
    ack_now   = mem && (mem_op.lat <= TIMEOUT) && (k == mem_op.lat);
    exp_stall = mem && (k < occupancy(mem_op) - 1);
    dm.dmem_ack   = mem ? ack_now : 1'($urandom_range(0, 1));
    dm.dmem_rdata = ack_now ? mem_op.rdata : $urandom;
    #4;
    chk("dmem_req", 32'(dm.dmem_req), 32'(mem));
    chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
    chk("mem_err", 32'(mem_err), 32'(m_err));
    chk("EX_MEM_data", EX_MEM_data, mem_op.alu);
    chk("EX_MEM_RegWrite", 32'(EX_MEM_RegWrite), 32'(mem_op.rw));
    chk("EX_MEM_RegisterRd", 32'(EX_MEM_RegisterRd), 32'(mem_op.rd));
    chk("MEM_WB_data", MEM_WB_data, m_wb_data);
    chk("MEM_WB_RegWrite", 32'(MEM_WB_RegWrite), 32'(m_wb_rw));
    chk("MEM_WB_RegisterRd", 32'(MEM_WB_RegisterRd), 32'(m_wb_rd));
    if (mem) begin
      chk("dmem_we", 32'(dm.dmem_we), 32'(mem_op.is_st));
      chk("dmem_addr", dm.dmem_addr, mem_op.alu);
      chk("dmem_wdata", dm.dmem_wdata, mem_op.wd);
    end
    @(posedge clk);
    #1;
    if (!exp_stall) begin
      retire(mem_op);
      mem_op = ex;
      k = 0;
      if (pending.size() > 0) void'(pending.pop_front());
    end else begin
      k++;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((pending.size() > 0 || is_mem(mem_op)) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) begin
      n_total++;
      $error("FAIL drain: pipeline still busy after %0d cycles, expected empty", guard);
    end
    step();
    step();
  endtask

  // Reset asserted mid-cycle: every output must clear before the next edge.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst dmem_req", 32'(dm.dmem_req), 32'd0);
    chk("rst mem_stall", 32'(mem_stall), 32'd0);
    chk("rst mem_err", 32'(mem_err), 32'd0);
    chk("rst EX_MEM_data", EX_MEM_data, 32'd0);
    chk("rst EX_MEM_RegWrite", 32'(EX_MEM_RegWrite), 32'd0);
    chk("rst EX_MEM_RegisterRd", 32'(EX_MEM_RegisterRd), 32'd0);
    chk("rst MEM_WB_data", MEM_WB_data, 32'd0);
    chk("rst MEM_WB_RegWrite", 32'(MEM_WB_RegWrite), 32'd0);
    chk("rst MEM_WB_RegisterRd", 32'(MEM_WB_RegisterRd), 32'd0);
    drive_ex(nop());
    dm.dmem_ack = 1'b0;
    mem_op    = nop();
    k         = 0;
    m_wb_data = '0;
    m_wb_rw   = 0;
    m_wb_rd   = '0;
    m_err     = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dm.dmem_ack   = 1'b0;
    dm.dmem_rdata = '0;
    mem_op    = nop();
    k         = 0;
    m_wb_data = '0;
    m_wb_rw   = 0;
    m_wb_rd   = '0;
    m_err     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ALU result passes through EX/MEM then MEM/WB
    pending.push_back(mk(0, 1, 5'd5, 32'h1234, 32'h0, 0, 32'h0));
    drain();

    // Load acked three cycles after the request
    pending.push_back(mk(1, 1, 5'd7, 32'h40, 32'h0, 3, 32'hCAFEF00D));
    drain();

    // Zero-wait store
    pending.push_back(mk(2, 0, 5'd3, 32'h80, 32'hA5A5A5A5, 0, 32'h0));
    drain();

    // Hung load times out, then an ALU op proves the pipeline resumes
    pending.push_back(mk(1, 1, 5'd9, 32'h100, 32'h0, TIMEOUT + 10, 32'hDEADBEEF));
    pending.push_back(mk(0, 1, 5'd12, 32'h5555, 32'h0, 0, 32'h0));
    drain();

    // Back-to-back single-wait loads
    pending.push_back(mk(1, 1, 5'd10, 32'h200, 32'h0, 1, 32'h11111111));
    pending.push_back(mk(1, 1, 5'd11, 32'h204, 32'h0, 1, 32'h22222222));
    drain();

    // Reset pulse clears the sticky error and every register
    step();
    pulse_reset();

    // Reset while an access is waiting, then a normal load
    pending.push_back(mk(1, 1, 5'd4, 32'h300, 32'h0, TIMEOUT + 10, 32'h0));
    pending.push_back(mk(0, 1, 5'd6, 32'h77, 32'h0, 0, 32'h0));
    repeat (4) step();
    pulse_reset();
    pending.push_back(mk(1, 1, 5'd8, 32'h304, 32'h0, 2, 32'h0BADF00D));
    drain();

    // Ack on the last permitted cycle and one before it
    pending.push_back(mk(1, 1, 5'd13, 32'h400, 32'h0, TIMEOUT, 32'h13131313));
    pending.push_back(mk(1, 1, 5'd14, 32'h404, 32'h0, TIMEOUT - 1, 32'h14141414));
    pending.push_back(mk(2, 0, 5'd0, 32'h408, 32'h99999999, TIMEOUT + 3, 32'h0));
    drain();

    // Random instruction stream
    for (int i = 0; i < 300; i++) pending.push_back(rand_op());
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
